// File: rtl/vga_sync_generator_if.sv
// Scan-position bundle between the VGA timing generator (master) and the pixel colour stage (slave).
// The slave side owns enable, which freezes the whole raster while low.
interface vga_sync_generator_if;
    logic       enable;
    logic [9:0] pixelCnt;
    logic [8:0] lineCnt;
    logic       hSync;
    logic       vSync;
    logic       videoOn;
    logic       pixelTick;
    logic       lineStart;
    logic       frameStart;

    modport master (
        input  enable,
        output pixelCnt, lineCnt, hSync, vSync, videoOn,
               pixelTick, lineStart, frameStart
    );

    modport slave (
        output enable,
        input  pixelCnt, lineCnt, hSync, vSync, videoOn,
               pixelTick, lineStart, frameStart
    );
endinterface

// File: rtl/vga_sync_generator.sv
// VGA raster timing generator: counters, sync and blanking all registered from next-state, so flags carry zero skew.
// No backpressure; enable=0 freezes every register and forces the strobes to 0.
module vga_sync_generator #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 400,
    parameter int V_FRONT    = 12,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 35,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int CLK_DIV    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    vga_sync_generator_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);

    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_VIS    = 9'(V_DISPLAY);
    localparam logic [8:0] VS_FIRST = 9'(V_DISPLAY + V_FRONT);
    localparam logic [8:0] VS_LAST  = 9'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] divCnt;
    logic [9:0] pixelCnt;
    logic [9:0] pixelNext;
    logic [8:0] lineCnt;
    logic [8:0] lineNext;
    logic       hSync;
    logic       vSync;
    logic       videoOn;
    logic       pixelTick;
    logic       lineStart;
    logic       frameStart;

    logic       pixelStep;
    logic       hSyncNext;
    logic       vSyncNext;
    logic       videoNext;

    assign pixelStep = vga.enable && (divCnt == DIV_LAST);

    always_comb begin
        pixelNext = pixelCnt;
        lineNext  = lineCnt;
        if (pixelStep) begin
            if (pixelCnt == H_LAST) begin
                pixelNext = '0;
                lineNext  = (lineCnt == V_LAST) ? '0 : lineCnt + 9'd1;
            end else begin
                pixelNext = pixelCnt + 10'd1;
            end
        end
    end

    // Decode the position about to be presented, not the current one, so flags land with their counters.
    assign hSyncNext = ((pixelNext >= HS_FIRST) && (pixelNext <= HS_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
    assign vSyncNext = ((lineNext  >= VS_FIRST) && (lineNext  <= VS_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
    assign videoNext = (pixelNext < H_VIS) && (lineNext < V_VIS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divCnt     <= '0;
            pixelCnt   <= H_LAST;
            lineCnt    <= V_LAST;
            hSync      <= ~H_SYNC_POL;
            vSync      <= ~V_SYNC_POL;
            videoOn    <= 1'b0;
            pixelTick  <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            if (vga.enable) begin
                divCnt <= pixelStep ? 4'd0 : divCnt + 4'd1;
            end
            pixelCnt   <= pixelNext;
            lineCnt    <= lineNext;
            hSync      <= hSyncNext;
            vSync      <= vSyncNext;
            videoOn    <= videoNext;
            pixelTick  <= pixelStep;
            lineStart  <= pixelStep && (pixelNext == 10'd0);
            frameStart <= pixelStep && (pixelNext == 10'd0) && (lineNext == 9'd0);
        end
    end

    assign vga.pixelCnt   = pixelCnt;
    assign vga.lineCnt    = lineCnt;
    assign vga.hSync      = hSync;
    assign vga.vSync      = vSync;
    assign vga.videoOn    = videoOn;
    assign vga.pixelTick  = pixelTick;
    assign vga.lineStart  = lineStart;
    assign vga.frameStart = frameStart;
endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: default, divide-by-2 and two small-raster instances share clock/reset/enable.
module tb_vga_sync_generator;
    typedef struct packed {
        logic [9:0] pix;
        logic [8:0] lin;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       tick;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int ht, hd, hf, hw, vt, vd, vf, vw, div;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        bit   rst;
        bit   en;
        obs_t exp;
    } vec_t;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clock = ~clock;

    vga_sync_generator_if if0 ();
    vga_sync_generator_if if1 ();
    vga_sync_generator_if if2 ();
    vga_sync_generator_if if3 ();
    assign if0.enable = enable;
    assign if1.enable = enable;
    assign if2.enable = enable;
    assign if3.enable = enable;

    vga_sync_generator u0 (.clock(clock), .reset(reset), .vga(if0));
    vga_sync_generator #(.CLK_DIV(2)) u1 (.clock(clock), .reset(reset), .vga(if1));
    vga_sync_generator #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(1)
    ) u2 (.clock(clock), .reset(reset), .vga(if2));
    vga_sync_generator #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(3)
    ) u3 (.clock(clock), .reset(reset), .vga(if3));

    function automatic obs_t grab(input int idx);
        obs_t o;
        case (idx)
            0:       o = {if0.pixelCnt, if0.lineCnt, if0.hSync, if0.vSync, if0.videoOn, if0.pixelTick, if0.lineStart, if0.frameStart};
            1:       o = {if1.pixelCnt, if1.lineCnt, if1.hSync, if1.vSync, if1.videoOn, if1.pixelTick, if1.lineStart, if1.frameStart};
            2:       o = {if2.pixelCnt, if2.lineCnt, if2.hSync, if2.vSync, if2.videoOn, if2.pixelTick, if2.lineStart, if2.frameStart};
            default: o = {if3.pixelCnt, if3.lineCnt, if3.hSync, if3.vSync, if3.videoOn, if3.pixelTick, if3.lineStart, if3.frameStart};
        endcase
        return o;
    endfunction

    function automatic obs_t mk(input int p, input int l, input bit hs, input bit vs,
                                input bit vid, input bit tk, input bit ls, input bit fs);
        return {10'(p), 9'(l), hs, vs, vid, tk, ls, fs};
    endfunction

    // Position is derived from the number of enabled edges since reset: every div-th one is a pixel step,
    // and step k (k>=1) presents raster index k-1 taken modulo the frame size.
    function automatic obs_t model(input cfg_t c, input int e, input bit enabledEdge);
        obs_t o;
        int k, idx, p, l;
        bit tk;
        k = e / c.div;
        if (k == 0) begin
            p = c.ht - 1;
            l = c.vt - 1;
        end else begin
            idx = (k - 1) % (c.ht * c.vt);
            p   = idx % c.ht;
            l   = idx / c.ht;
        end
        tk = enabledEdge && (e > 0) && (e % c.div == 0);
        o.pix  = 10'(p);
        o.lin  = 9'(l);
        o.hs   = (p >= c.hd + c.hf && p < c.hd + c.hf + c.hw) ? c.hp : !c.hp;
        o.vs   = (l >= c.vd + c.vf && l < c.vd + c.vf + c.vw) ? c.vp : !c.vp;
        o.vid  = (p < c.hd) && (l < c.vd);
        o.tick = tk;
        o.ls   = tk && (p == 0);
        o.fs   = tk && (p == 0) && (l == 0);
        return o;
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got pix=%0d lin=%0d hs=%b vs=%b vid=%b tick=%b ls=%b fs=%b, want pix=%0d lin=%0d hs=%b vs=%b vid=%b tick=%b ls=%b fs=%b",
                     name, act.pix, act.lin, act.hs, act.vs, act.vid, act.tick, act.ls, act.fs,
                     exp.pix, exp.lin, exp.hs, exp.vs, exp.vid, exp.tick, exp.ls, exp.fs);
        end
    endtask

    task automatic chkInt(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clk();
        @(posedge clock);
        #1;
    endtask

    cfg_t cfg [4];
    vec_t vecs[8];
    obs_t rst0, o0, o1, o2, o3;
    obs_t d1exp[4];
    int   hsLow, hsBadPos, vidOn, vsOn2, vidBad2;
    int   fs2[2], fs3[2];
    int   fs2n, fs3n;
    int   ecnt[4];
    bit   rstNow;

    initial begin
        cfg[0] = '{ht:800, hd:640, hf:16, hw:96, vt:449, vd:400, vf:12, vw:2, div:1, hp:1'b0, vp:1'b1};
        cfg[1] = '{ht:800, hd:640, hf:16, hw:96, vt:449, vd:400, vf:12, vw:2, div:2, hp:1'b0, vp:1'b1};
        cfg[2] = '{ht:15,  hd:8,   hf:2,  hw:3,  vt:13,  vd:6,   vf:2,  vw:2, div:1, hp:1'b0, vp:1'b1};
        cfg[3] = '{ht:15,  hd:8,   hf:2,  hw:3,  vt:13,  vd:6,   vf:2,  vw:2, div:3, hp:1'b0, vp:1'b1};

        rst0 = mk(799, 448, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[0] = '{rst:1'b0, en:1'b1, exp:rst0};
        vecs[1] = '{rst:1'b1, en:1'b1, exp:mk(0, 0, 1, 0, 1, 1, 1, 1)};
        vecs[2] = '{rst:1'b1, en:1'b1, exp:mk(1, 0, 1, 0, 1, 1, 0, 0)};
        vecs[3] = '{rst:1'b1, en:1'b0, exp:mk(1, 0, 1, 0, 1, 0, 0, 0)};
        vecs[4] = '{rst:1'b1, en:1'b0, exp:mk(1, 0, 1, 0, 1, 0, 0, 0)};
        vecs[5] = '{rst:1'b1, en:1'b1, exp:mk(2, 0, 1, 0, 1, 1, 0, 0)};
        vecs[6] = '{rst:1'b0, en:1'b1, exp:rst0};
        vecs[7] = '{rst:1'b1, en:1'b1, exp:mk(0, 0, 1, 0, 1, 1, 1, 1)};

        d1exp[0] = rst0;
        d1exp[1] = mk(0, 0, 1, 0, 1, 1, 1, 1);
        d1exp[2] = mk(0, 0, 1, 0, 1, 0, 0, 0);
        d1exp[3] = mk(1, 0, 1, 0, 1, 1, 0, 0);

        // Table: reset, release, short enable gap, reset again.
        for (int i = 0; i < 8; i++) begin
            reset  = vecs[i].rst;
            enable = vecs[i].en;
            clk();
            chk($sformatf("vec%0d", i), grab(0), vecs[i].exp);
        end

        // Free run from release: line timing on u0, divide-by-2 start on u1, frame timing on u2/u3.
        reset = 1'b0; enable = 1'b1;
        clk();
        reset = 1'b1;
        hsLow = 0; hsBadPos = 0; vidOn = 0; vsOn2 = 0; vidBad2 = 0;
        fs2n = 0; fs3n = 0; fs2[0] = 0; fs2[1] = 0; fs3[0] = 0; fs3[1] = 0;
        for (int n = 1; n <= 1200; n++) begin
            clk();
            o0 = grab(0); o1 = grab(1); o2 = grab(2); o3 = grab(3);
            if (n <= 800) begin
                if (o0.hs == 1'b0) hsLow++;
                if ((o0.hs == 1'b0) != (o0.pix >= 656 && o0.pix <= 751)) hsBadPos++;
                if (o0.vid) vidOn++;
            end
            if (n == 801) chk("line wrap", o0, mk(0, 1, 1, 0, 1, 1, 1, 0));
            if (n <= 4) chk($sformatf("div2 edge%0d", n), o1, d1exp[n-1]);
            if (o2.fs) begin
                if (fs2n < 2) fs2[fs2n] = n;
                fs2n++;
            end
            if (o3.fs) begin
                if (fs3n < 2) fs3[fs3n] = n;
                fs3n++;
            end
            if (n <= 195 && o2.vs) vsOn2++;
            if (o2.lin >= 6 && o2.vid) vidBad2++;
        end
        chkInt("hsync low clocks", hsLow, 96);
        chkInt("hsync position", hsBadPos, 0);
        chkInt("video clocks per line", vidOn, 640);
        chkInt("vsync clocks per frame", vsOn2, 30);
        chkInt("video in vblank", vidBad2, 0);
        chkInt("small frame first", fs2[0], 1);
        chkInt("small frame period", fs2[1] - fs2[0], 195);
        chkInt("div3 frame first", fs3[0], 3);
        chkInt("div3 frame period", fs3[1] - fs3[0], 585);

        // Enable gap at pixel 100, then an asynchronous reset at pixel 300.
        reset = 1'b0;
        clk();
        reset = 1'b1;
        for (int n = 0; n < 101; n++) clk();
        chk("reach 100", grab(0), mk(100, 0, 1, 0, 1, 1, 0, 0));
        enable = 1'b0;
        for (int n = 0; n < 10; n++) begin
            clk();
            chk($sformatf("hold%0d", n), grab(0), mk(100, 0, 1, 0, 1, 0, 0, 0));
        end
        enable = 1'b1;
        clk();
        chk("resume", grab(0), mk(101, 0, 1, 0, 1, 1, 0, 0));
        for (int n = 0; n < 199; n++) clk();
        chk("reach 300", grab(0), mk(300, 0, 1, 0, 1, 1, 0, 0));
        reset = 1'b0;
        #1;
        chk("async reset", grab(0), rst0);
        chk("async reset small", grab(2), mk(14, 12, 1, 0, 0, 0, 0, 0));
        clk();
        reset = 1'b1;
        clk();
        chk("restart edge1", grab(0), mk(0, 0, 1, 0, 1, 1, 1, 1));
        clk();
        chk("restart edge2", grab(0), mk(1, 0, 1, 0, 1, 1, 0, 0));

        // Random enable and occasional reset against the edge-count model.
        reset = 1'b0;
        clk();
        for (int d = 0; d < 4; d++) ecnt[d] = 0;
        for (int n = 0; n < 6000; n++) begin
            rstNow = ($urandom_range(0, 1499) == 0);
            reset  = !rstNow;
            enable = ($urandom_range(0, 3) != 0);
            clk();
            for (int d = 0; d < 4; d++) begin
                if (rstNow) ecnt[d] = 0;
                else if (enable) ecnt[d]++;
                chk($sformatf("rand d%0d n%0d", d, n), grab(d),
                    model(cfg[d], ecnt[d], !rstNow && enable));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
